// File: rtl/mos6502_int_sequencer.sv
// Interrupt front end for the 6502 core: NMI/IRQ polling, T0 handoff and SO edge pulse.
// Optional MOS6502_INT_SYNC_EN adds SYNC_STAGES-deep input synchronisers.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | no interrupt committed or in service
// ST_NMI_T0| NMI accepted at poll, waiting for T0
// ST_IRQ_T0| IRQ accepted at poll, waiting for T0
// ST_NMI_SV| NMI service sequence running until next poll
// ST_IRQ_SV| IRQ service sequence running until next poll
module mos6502_int_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nRESET,
  input  logic clk_en,
  input  logic nNMI,
  input  logic nIRQ,
  input  logic nSO,
  input  logic T0,
  input  logic NEXT_T,
  input  logic I_mask,
  output logic nNMI_T0,
  output logic nIRQ_T0,
  output logic nNMI_req,
  output logic nIRQ_req,
  output logic SO_req,
  output logic nmi_pend
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NMI_T0 = 3'd1,
    ST_IRQ_T0 = 3'd2,
    ST_NMI_SV = 3'd3,
    ST_IRQ_SV = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   s_nmi, s_irq, s_so;
  logic   prev_nmi, prev_so;
  logic   nmi_edge, irq_act, poll, accept;

  if (SYNC_STAGES < 2) begin : g_sync_stages_too_small
  end

`ifdef MOS6502_INT_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_nmi, sync_irq, sync_so;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sync_nmi <= '1;
      sync_irq <= '1;
      sync_so  <= '1;
    end else begin
      sync_nmi <= {sync_nmi[SYNC_STAGES-2:0], nNMI};
      sync_irq <= {sync_irq[SYNC_STAGES-2:0], nIRQ};
      sync_so  <= {sync_so[SYNC_STAGES-2:0], nSO};
    end
  end

  assign s_nmi = sync_nmi[SYNC_STAGES-1];
  assign s_irq = sync_irq[SYNC_STAGES-1];
  assign s_so  = sync_so[SYNC_STAGES-1];
`else
  assign s_nmi = nNMI;
  assign s_irq = nIRQ;
  assign s_so  = nSO;
`endif

  assign nmi_edge = prev_nmi & ~s_nmi;
  assign irq_act  = ~s_irq & ~I_mask;
  assign poll     = clk_en & NEXT_T;
  assign accept   = clk_en & T0 & ~NEXT_T;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      prev_nmi <= 1'b1;
      prev_so  <= 1'b1;
      SO_req   <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clk_en) begin
        prev_nmi <= s_nmi;
        prev_so  <= s_so;
        SO_req   <= prev_so & ~s_so;
        // a fresh edge in the accept cycle must survive the clear
        if (nmi_edge)
          nmi_pend <= 1'b1;
        else if (accept && state == ST_NMI_T0)
          nmi_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (poll) begin
      if (nmi_pend)
        state_nxt = ST_NMI_T0;
      else if (irq_act)
        state_nxt = ST_IRQ_T0;
      else
        state_nxt = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_NMI_T0: state_nxt = ST_NMI_SV;
        ST_IRQ_T0: state_nxt = ST_IRQ_SV;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nNMI_T0  = 1'b1;
    nIRQ_T0  = 1'b1;
    nNMI_req = 1'b1;
    nIRQ_req = 1'b1;
    case (state)
      ST_NMI_T0: nNMI_T0  = 1'b0;
      ST_IRQ_T0: nIRQ_T0  = 1'b0;
      ST_NMI_SV: nNMI_req = 1'b0;
      ST_IRQ_SV: nIRQ_req = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mos6502_int_sequencer.sv
// Scoreboard bench for mos6502_int_sequencer (default build: pins feed the logic directly).
module tb_mos6502_int_sequencer;

  logic clk = 1'b0;
  logic nRESET, clk_en, nNMI, nIRQ, nSO, T0, NEXT_T, I_mask;
  logic nNMI_T0, nIRQ_T0, nNMI_req, nIRQ_req, SO_req, nmi_pend;

  mos6502_int_sequencer dut (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .nNMI(nNMI), .nIRQ(nIRQ),
    .nSO(nSO), .T0(T0), .NEXT_T(NEXT_T), .I_mask(I_mask),
    .nNMI_T0(nNMI_T0), .nIRQ_T0(nIRQ_T0), .nNMI_req(nNMI_req),
    .nIRQ_req(nIRQ_req), .SO_req(SO_req), .nmi_pend(nmi_pend)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  // Reference model: which interrupt is committed to T0 / being serviced (0 none, 1 NMI, 2 IRQ)
  int m_t0, m_req;
  bit m_pend, m_prev_nmi, m_prev_so, m_so_req;

  function automatic logic [5:0] m_out();
    return {m_t0 != 1, m_t0 != 2, m_req != 1, m_req != 2, m_so_req, m_pend};
  endfunction

  function automatic void m_reset();
    m_t0 = 0; m_req = 0; m_pend = 0;
    m_prev_nmi = 1; m_prev_so = 1; m_so_req = 0;
  endfunction

  function automatic logic [5:0] dut_out();
    return {nNMI_T0, nIRQ_T0, nNMI_req, nIRQ_req, SO_req, nmi_pend};
  endfunction

  task automatic cyc(input bit en, input bit nmi, input bit irq, input bit so,
                     input bit t0, input bit nt, input bit im);
    int nt0, nreq;
    bit npend;
    @(negedge clk);
    clk_en = en; nNMI = nmi; nIRQ = irq; nSO = so; T0 = t0; NEXT_T = nt; I_mask = im;
    if (en) begin
      nt0 = m_t0; nreq = m_req; npend = m_pend;
      if (nt) begin
        nt0  = m_pend ? 1 : ((!irq && !im) ? 2 : 0);
        nreq = 0;
      end else if (t0) begin
        nreq = m_t0;
        nt0  = 0;
        if (m_t0 == 1) npend = 0;
      end
      if (m_prev_nmi && !nmi) npend = 1;
      m_so_req = m_prev_so && !so;
      m_prev_nmi = nmi; m_prev_so = so;
      m_t0 = nt0; m_req = nreq; m_pend = npend;
    end
    exp_q.push_back(m_out());
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string name);
    n_vec++;
    if (dut_out() !== 6'b111100) begin
      n_err++;
      $display("FAIL %s: outputs got %b required 111100", name, dut_out());
    end
  endtask

  // Monitor: outputs are presented every clock; compare against the queued prediction.
  initial begin
    logic [5:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_out();
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got %b required %b (nNMI_T0 nIRQ_T0 nNMI_req nIRQ_req SO_req nmi_pend)",
                   $time, g, e);
        end
        n_vec++;
        if ((!g[5] && !g[4]) || (!g[3] && !g[2])) begin
          n_err++;
          $display("FAIL exclusion @%0t: got %b required at most one T0 and one req low", $time, g);
        end
      end
    end
  end

  initial begin
    bit r_en, r_nmi, r_irq, r_so, r_t0, r_nt, r_im;
    nRESET = 0; clk_en = 0; nNMI = 1; nIRQ = 1; nSO = 1; T0 = 0; NEXT_T = 0; I_mask = 1;
    m_reset();

    // reset held while pins toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clk_en = 1; nNMI = i[0]; nIRQ = i[1]; nSO = ~i[0]; T0 = i[1]; NEXT_T = ~i[1]; I_mask = i[0];
      #1 chk_reset("reset_hold");
    end
    @(negedge clk);
    nNMI = 1; nIRQ = 1; nSO = 1; T0 = 0; NEXT_T = 0;
    nRESET = 1;

    // NMI pulse, poll, accept, end of service, no re-trigger while held low
    repeat (2) cyc(1, 1, 1, 1, 0, 0, 1);
    repeat (3) cyc(1, 0, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 1, 1);
    cyc(0, 1, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 1, 0, 1);
    repeat (3) cyc(1, 1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 1, 1);
    repeat (2) cyc(1, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 1, 0, 1);
    repeat (2) cyc(1, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 1, 0, 1);
    cyc(1, 0, 1, 1, 0, 1, 1);
    cyc(1, 1, 1, 1, 0, 0, 1);

    // IRQ masking, then unmasked service; withdrawn after poll still serviced
    cyc(1, 1, 0, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 1, 0, 1);
    cyc(1, 1, 0, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 0);
    repeat (2) cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1, 0);

    // NMI beats IRQ; IRQ taken at the following poll; NEXT_T&T0 acts as poll
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1, 1);

    // SO edge with clk_en gaps
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 0, 1);

    // async reset during NMI service
    cyc(1, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 0, 1);
    drain();
    #1 nRESET = 0;
    #1 chk_reset("reset_mid_service");
    m_reset();
    @(negedge clk);
    #1 chk_reset("reset_after_clock");
    nNMI = 1; nIRQ = 1; nSO = 1; T0 = 0; NEXT_T = 0;
    nRESET = 1;

    // randomized traffic
    r_nmi = 1; r_irq = 1; r_so = 1; r_im = 1;
    for (int i = 0; i < 3000; i++) begin
      r_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) r_nmi = ~r_nmi;
      if ($urandom_range(0, 5) == 0) r_irq = ~r_irq;
      if ($urandom_range(0, 4) == 0) r_so = ~r_so;
      if ($urandom_range(0, 9) == 0) r_im = ~r_im;
      r_t0 = ($urandom_range(0, 4) == 0);
      r_nt = ($urandom_range(0, 5) == 0);
      cyc(r_en, r_nmi, r_irq, r_so, r_t0, r_nt, r_im);
    end
    drain();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
